// File: rtl/mole_game_core.sv
// Whack-a-mole game core: LFSR mole picker, synchronised button edge detect, round/score FSM.
// Optional wrong-hole score penalty is built when MOLE_MISS_PENALTY_EN is defined.
module mole_game_core #(
  parameter int N_HOLES    = 8,
  parameter int LFSR_W     = 16,
  parameter int SCORE_W    = 8,
  parameter int MOLE_TICKS = 50_000_000,
  parameter int GAP_TICKS  = 12_500_000,
  parameter int ROUNDS     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_HOLES-1:0] button,
  output logic [N_HOLES-1:0] led,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_cnt,
  output logic               busy,
  output logic               game_over,
  output logic               hit_pulse
);
  localparam int IDX_W     = $clog2(N_HOLES);
  localparam int MAX_TICKS = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
  localparam int TMR_W     = $clog2(MAX_TICKS + 1);
  localparam int RND_W     = $clog2(ROUNDS + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Maximal-length feedback taps, bit (t-1) set for polynomial term x^t.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_B400;
    endcase
  endfunction

  function automatic logic [31:0] seed_val(input int w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < w; i++) s[i] = ((w - 1 - i) % 2 == 0);
    if (w == 16) s = 32'h0000_ACE1;
    return s;
  endfunction

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(tap_mask(LFSR_W));
  localparam logic [LFSR_W-1:0] SEED = LFSR_W'(seed_val(LFSR_W));

  typedef enum logic [2:0] {S_IDLE, S_PICK, S_SHOW, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [N_HOLES-1:0] sync1_q, sync1_d, sync2_q, sync2_d, btn_prev_q, btn_prev_d;
  logic [N_HOLES-1:0] led_q, led_d;
  logic [SCORE_W-1:0] score_q, score_d, miss_q, miss_d;
  logic               busy_q, busy_d, game_over_q, game_over_d, hit_pulse_q, hit_pulse_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic [IDX_W-1:0]   prev_hole_q, prev_hole_d;
  logic               prev_valid_q, prev_valid_d;

  logic [N_HOLES-1:0] press, cand_onehot;
  logic [IDX_W-1:0]   cand;
  logic               cand_ok;

  assign press   = sync2_q & ~btn_prev_q;
  assign cand    = lfsr_q[IDX_W-1:0];
  assign cand_ok = (int'(cand) < N_HOLES) && !(prev_valid_q && (cand == prev_hole_q));

  for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_dec
    assign cand_onehot[gi] = (cand == IDX_W'(gi));
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    sync1_d      = button;
    sync2_d      = sync1_q;
    btn_prev_d   = sync2_q;
    led_d        = led_q;
    score_d      = score_q;
    miss_d       = miss_q;
    hit_pulse_d  = 1'b0;
    tmr_d        = tmr_q;
    round_d      = round_q;
    prev_hole_d  = prev_hole_q;
    prev_valid_d = prev_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PICK;
          score_d = '0;
          miss_d  = '0;
          round_d = '0;
        end
      end
      S_PICK: begin
        if (cand_ok) begin
          led_d        = cand_onehot;
          prev_hole_d  = cand;
          prev_valid_d = 1'b1;
          tmr_d        = TMR_W'(MOLE_TICKS - 1);
          state_d      = S_SHOW;
        end
      end
      S_SHOW: begin
        // A lit-hole event beats both a same-cycle timeout and any wrong-hole events.
        if (|(press & led_q)) begin
          if (score_q != SCORE_MAX) score_d = score_q + 1'b1;
          hit_pulse_d = 1'b1;
          led_d       = '0;
          tmr_d       = TMR_W'(GAP_TICKS - 1);
          state_d     = S_GAP;
        end else begin
`ifdef MOLE_MISS_PENALTY_EN
          if (|(press & ~led_q) && (score_q != '0)) score_d = score_q - 1'b1;
`endif
          if (tmr_q == '0) begin
            if (miss_q != SCORE_MAX) miss_d = miss_q + 1'b1;
            led_d   = '0;
            tmr_d   = TMR_W'(GAP_TICKS - 1);
            state_d = S_GAP;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tmr_q == '0) begin
          round_d = round_q + 1'b1;
          state_d = (round_q == RND_W'(ROUNDS - 1)) ? S_DONE : S_PICK;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d == S_PICK) || (state_d == S_SHOW) || (state_d == S_GAP);
    game_over_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      sync1_q      <= '0;
      sync2_q      <= '0;
      btn_prev_q   <= '0;
      led_q        <= '0;
      score_q      <= '0;
      miss_q       <= '0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      hit_pulse_q  <= 1'b0;
      tmr_q        <= '0;
      round_q      <= '0;
      prev_hole_q  <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_prev_q   <= btn_prev_d;
      led_q        <= led_d;
      score_q      <= score_d;
      miss_q       <= miss_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      hit_pulse_q  <= hit_pulse_d;
      tmr_q        <= tmr_d;
      round_q      <= round_d;
      prev_hole_q  <= prev_hole_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign led       = led_q;
  assign score     = score_q;
  assign miss_cnt  = miss_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign hit_pulse = hit_pulse_q;

endmodule

// File: doc/mole_game_core.md
MOLE_GAME_CORE -- requirements
Module: mole_game_core

Interface
REQ-001 Parameter N_HOLES, default 8: number of holes/LEDs/buttons, 2..16.
REQ-002 Parameter LFSR_W, default 16: random generator width, 8..32.
REQ-003 Parameter SCORE_W, default 8: width of score and miss counters.
REQ-004 Parameter MOLE_TICKS, default 50_000_000: clk cycles a mole stays lit.
REQ-005 Parameter GAP_TICKS, default 12_500_000: clk cycles all LEDs stay dark between moles.
REQ-006 Parameter ROUNDS, default 32: moles per game.
REQ-007 clk  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  level; a start request is sampled on any cycle start=1 in IDLE or DONE.
REQ-010 button  input  N_HOLES  asynchronous raw push-buttons, active-high.
REQ-011 led  output  N_HOLES  one-hot lit mole, all-zero when no mole is shown.
REQ-012 score  output  SCORE_W  hit count of current/last game.
REQ-013 miss_cnt  output  SCORE_W  timed-out moles of current/last game.
REQ-014 busy  output  1  high in PICK, SHOW, GAP.
REQ-015 game_over  output  1  high in DONE.
REQ-016 hit_pulse  output  1  one-cycle pulse on each registered hit.

Function
REQ-017 FSM states IDLE, PICK, SHOW, GAP, DONE; all outputs registered.
REQ-018 IDLE/DONE + start=1 -> PICK next cycle; score, miss_cnt, round counter cleared on that transition.
REQ-019 LFSR: maximal-length Fibonacci, advances every cycle in every state, never all-zero; LFSR_W=16 taps 16,14,13,11.
REQ-020 PICK: candidate = LFSR low ceil(log2(N_HOLES)) bits; accepted only if < N_HOLES and != previous hole; otherwise stay in PICK next cycle.
REQ-021 On acceptance: led = one-hot(candidate) from the next cycle, state -> SHOW, show-timer loaded with MOLE_TICKS-1.
REQ-022 Buttons pass a 2-flop synchroniser then rising-edge detect; a press event exists in the cycle after the second sync flop first samples 1; held buttons produce one event.
REQ-023 SHOW, press event on lit hole: score += 1 (saturates at all-ones), hit_pulse=1 for one cycle, led=0, -> GAP.
REQ-024 SHOW, timer expiry with no hit: miss_cnt += 1 (saturating), led=0, -> GAP.
REQ-025 SHOW, hit event and timer expiry same cycle: hit wins, miss_cnt unchanged.
REQ-026 SHOW, events on lit hole and other holes same cycle: counted as hit only.
REQ-027 Wrong-hole events without a lit-hole event: handling per REQ-034/035; mole stays lit.
REQ-028 Press events in IDLE, PICK, GAP, DONE are ignored.
REQ-029 GAP lasts GAP_TICKS cycles; then round counter += 1; if it reaches ROUNDS -> DONE else -> PICK.
REQ-030 DONE holds score/miss_cnt stable, game_over=1, led=0 until start or reset.
REQ-031 start asserted while busy is ignored.

Reset
REQ-032 reset=1 at a clock edge, in any state including mid-game: state=IDLE, led=0, score=0, miss_cnt=0, busy=0, game_over=0, hit_pulse=0, round counter=0, previous hole = none, sync/edge flops=0.
REQ-033 LFSR reset seed: alternating 1010... pattern (16'hACE1 for LFSR_W=16); never zero.

Configuration
REQ-034 Macro MOLE_MISS_PENALTY_EN defined: a wrong-hole event in SHOW decrements score by 1, saturating at 0, once per cycle regardless of how many wrong buttons.
REQ-035 Macro MOLE_MISS_PENALTY_EN undefined: wrong-hole events have no effect; no penalty logic synthesised.

Verification (N_HOLES=8, MOLE_TICKS=10, GAP_TICKS=4, ROUNDS=4, LFSR_W=16)
REQ-036 reset mid-SHOW with score=2 -> next cycle led=0, score=0, busy=0, state IDLE.
REQ-037 start, press lit hole 3 cycles after led asserts -> hit_pulse once, score=1, led=0 next cycle, GAP 4 cycles.
REQ-038 start, never press -> after 4 rounds game_over=1, miss_cnt=4, score=0; no two consecutive moles share a hole.
REQ-039 Press lit hole timed so event coincides with timer expiry -> score+1, miss_cnt unchanged.
REQ-040 Penalty build: score=1, press wrong hole twice in SHOW -> score=0 after both, mole still lit; non-penalty build -> score stays 1.
REQ-041 Score at all-ones (SCORE_W=2, score=3) + hit -> score stays 3, hit_pulse still pulses; start in DONE -> score=0, busy=1.
